// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and fill-counter width helper
package fifo_pkg;
  localparam int FIFO_MODE_REG = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: WORD x DEPTH storage, one write port, one write-first registered read port with sync zero
module fifo_ram #(
  parameter int WORD = 8,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [WORD-1:0] wdata_i,
  input  logic            re_i,
  input  logic [AW-1:0]   raddr_i,
  input  logic            zero_i,
  output logic [WORD-1:0] rdata_o
);
  logic [WORD-1:0] mem [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i) mem[waddr_i] <= wdata_i;
  // forwarding the write lets a word pushed into the head slot show up with no extra cycle
  always_ff @(posedge clk_i)
    rdata_o <= (!rst_ni || zero_i) ? '0 : !re_i ? rdata_o : (we_i && waddr_i == raddr_i) ? wdata_i : mem[raddr_i];
endmodule

// File: rtl/param_fifo.sv
// param_fifo: parameterised FIFO, registered or first-word-fall-through read.
// Sticky ovf_o/udf_o flags exist only when PARAM_FIFO_ERR_FLAGS_EN is defined.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WORD = 8,
  parameter int DEPTH = 8,
  parameter int AFULL = DEPTH - 1,
  parameter int AEMPTY = 1,
  parameter int FWFT = FIFO_MODE_REG
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_i,
  input  logic [WORD-1:0]              data_i,
  input  logic                         rd_i,
  input  logic                         clr_i,
  output logic [WORD-1:0]              data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         afull_o,
  output logic                         aempty_o,
  output logic [fill_width(DEPTH)-1:0] fill_o,
  output logic                         ovf_o,
  output logic                         udf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = fill_width(DEPTH);
  localparam bit FT = FWFT == FIFO_MODE_FWFT;
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [FW-1:0] fill_nxt;
  logic wr_en, rd_en;
  assign wr_en = wr_i && !full_o;
  assign rd_en = rd_i && !empty_o;
  assign wr_ptr_nxt = !wr_en ? wr_ptr : (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
  assign rd_ptr_nxt = !rd_en ? rd_ptr : (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
  assign fill_nxt = fill_o + FW'(wr_en) - FW'(rd_en);
  // flags derive from the next count so they stay aligned with fill_o
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_o   <= '0;
      full_o   <= 1'b0;
      empty_o  <= 1'b1;
      afull_o  <= 1'b0;
      aempty_o <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      fill_o   <= fill_nxt;
      full_o   <= fill_nxt == FW'(DEPTH);
      empty_o  <= fill_nxt == '0;
      afull_o  <= fill_nxt >= FW'(AFULL);
      aempty_o <= fill_nxt <= FW'(AEMPTY);
    end
  // FWFT keeps the output register tracking the next head every cycle
  fifo_ram #(.WORD(WORD), .DEPTH(DEPTH)) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (wr_en),
    .waddr_i (wr_ptr),
    .wdata_i (data_i),
    .re_i    (FT ? 1'b1 : rd_en),
    .raddr_i (FT ? rd_ptr_nxt : rd_ptr),
    .zero_i  (FT && fill_nxt == '0),
    .rdata_o (data_o)
  );
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      ovf_o <= (wr_i && full_o && !rd_en) || (ovf_o && !clr_i);
      udf_o <= (rd_i && empty_o) || (udf_o && !clr_i);
    end
`else
  logic unused_clr;
  assign unused_clr = clr_i;
  assign ovf_o = 1'b0;
  assign udf_o = 1'b0;
`endif
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed vectors for param_fifo (DEPTH=8 registered, DEPTH=5, DEPTH=8 FWFT)
module tb_param_fifo;
`ifdef PARAM_FIFO_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [7:0] data = '0;
  logic [7:0] d0, d5, df;
  logic [3:0] f0, ff;
  logic [2:0] f5;
  logic fu0, em0, af0, ae0, ov0, ud0;
  logic fu5, em5, af5, ae5, ov5, ud5;
  logic fuf, emf, aff, aef, ovf, udf;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  param_fifo u0 (.clk_i(clk), .rst_ni(rst_n), .wr_i(wr), .data_i(data), .rd_i(rd), .clr_i(clr),
    .data_o(d0), .full_o(fu0), .empty_o(em0), .afull_o(af0), .aempty_o(ae0), .fill_o(f0), .ovf_o(ov0), .udf_o(ud0));
  param_fifo #(.DEPTH(5)) u5 (.clk_i(clk), .rst_ni(rst_n), .wr_i(wr), .data_i(data), .rd_i(rd), .clr_i(clr),
    .data_o(d5), .full_o(fu5), .empty_o(em5), .afull_o(af5), .aempty_o(ae5), .fill_o(f5), .ovf_o(ov5), .udf_o(ud5));
  param_fifo #(.FWFT(1)) uf (.clk_i(clk), .rst_ni(rst_n), .wr_i(wr), .data_i(data), .rd_i(rd), .clr_i(clr),
    .data_o(df), .full_o(fuf), .empty_o(emf), .afull_o(aff), .aempty_o(aef), .fill_o(ff), .ovf_o(ovf), .udf_o(udf));
  typedef struct {
    logic w, r, c;
    logic [7:0] d;
    logic [17:0] exp;
  } vec_t;
  vec_t v[19];
  function automatic logic [17:0] st(input logic [7:0] d, input logic [3:0] f,
    input logic fu, em, af, ae, ov, ud);
    return {d, f, fu, em, af, ae, ov, ud};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    wr = w;
    rd = r;
    clr = c;
    data = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
    clr = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < 8; i++)
      v[i] = '{1'b1, 1'b0, 1'b0, 8'(i + 1), st(8'h00, 4'(i + 1), i == 7, 1'b0, i >= 6, i == 0, 1'b0, 1'b0)};
    v[8] = '{1'b1, 1'b0, 1'b0, 8'hFF, st(8'h00, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, ERR, 1'b0)};
    for (int i = 0; i < 8; i++)
      v[9 + i] = '{1'b0, 1'b1, 1'b0, 8'h00, st(8'(i + 1), 4'(7 - i), 1'b0, i == 7, i == 0, i >= 6, ERR, 1'b0)};
    v[17] = '{1'b0, 1'b1, 1'b0, 8'h00, st(8'h08, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, ERR, ERR)};
    v[18] = '{1'b0, 1'b0, 1'b1, 8'h00, st(8'h08, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)};
    do_reset();
    chk("reset_d8", 32'({d0, f0, fu0, em0, af0, ae0, ov0, ud0}), 32'(st(8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));
    chk("reset_fwft", 32'({df, ff, emf}), 32'({8'h00, 4'd0, 1'b1}));
    for (int i = 0; i < 19; i++) begin
      step(v[i].w, v[i].r, v[i].c, v[i].d);
      chk($sformatf("vec%0d", i), 32'({d0, f0, fu0, em0, af0, ae0, ov0, ud0}), 32'(v[i].exp));
    end
    // overflow set, clear, and clear racing a fresh overflow
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h21 + i));
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("ovf_set", 32'(ov0), 32'(ERR));
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("ovf_clr", 32'(ov0), 32'(1'b0));
    step(1'b1, 1'b0, 1'b1, 8'hEE);
    chk("ovf_clr_race", 32'(ov0), 32'(ERR));
    // simultaneous push/pop on full: pop wins
    step(1'b1, 1'b1, 1'b0, 8'h55);
    chk("full_wr_rd", 32'({d0, f0, fu0}), 32'({8'h21, 4'd7, 1'b0}));
    // simultaneous push/pop on empty: push wins, underflow flagged
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'h66);
    chk("empty_wr_rd", 32'({d0, f0, em0, ud0}), 32'({8'h00, 4'd1, 1'b0, ERR}));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("empty_wr_rd_pop", 32'({d0, em0}), 32'({8'h66, 1'b1}));
    // reset mid-operation with requests asserted
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h11 + i));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre_reset", 32'({d0, f0}), 32'({8'h11, 4'd3}));
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b1, 8'h77);
    rst_n = 1'b1;
    chk("mid_reset", 32'({d0, f0, fu0, em0, af0, ae0, ov0, ud0}), 32'(st(8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));
    step(1'b1, 1'b0, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_reset_rd", 32'({d0, em0}), 32'({8'h3C, 1'b1}));
    // DEPTH=5 pointer wrap
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("d5_pair%0d", i), 32'({d5, f5, em5}), 32'({8'(8'h10 + i), 3'd0, 1'b1}));
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    chk("d5_full", 32'({f5, fu5, af5, ov5}), 32'({3'd5, 1'b1, 1'b1, ERR}));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("d5_head", 32'({d5, f5, fu5}), 32'({8'h40, 3'd4, 1'b0}));
    // first-word-fall-through
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'hA5);
    chk("fwft_fall", 32'({df, emf, ff}), 32'({8'hA5, 1'b0, 4'd1}));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fwft_pop", 32'({df, emf}), 32'({8'h00, 1'b1}));
    step(1'b1, 1'b0, 1'b0, 8'hB1);
    step(1'b1, 1'b0, 1'b0, 8'hB2);
    chk("fwft_head", 32'({df, ff}), 32'({8'hB1, 4'd2}));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fwft_next", 32'({df, ff}), 32'({8'hB2, 4'd1}));
    step(1'b1, 1'b1, 1'b0, 8'hB3);
    chk("fwft_swap", 32'({df, ff, emf}), 32'({8'hB3, 4'd1, 1'b0}));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("fwft_drain", 32'({df, emf, aef}), 32'({8'h00, 1'b1, 1'b1}));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
